// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory access unit:
//   - DMType encodings presented by the CPU MEM stage
//   - response error codes
//   - access FSM state encoding
//   - small decode helpers for legality and alignment of a request
// -----------------------------------------------------------------------------
package dm_pkg;

  // Access type encodings (req_dmtype)
  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  // Response error codes (rsp_err)
  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  // Access FSM states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } dm_state_e;

  // Encodings 101..111 are reserved and rejected without a bus cycle
  function automatic logic dm_is_legal(input logic [2:0] dmtype);
    logic legal;
    case (dmtype)
      DM_WORD, DM_HALF, DM_HALF_U, DM_BYTE, DM_BYTE_U: legal = 1'b1;
      default:                                         legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Natural alignment check; bytes are always aligned
  function automatic logic dm_is_misaligned(input logic [2:0] dmtype,
                                            input logic [1:0] addr_lo);
    logic mis;
    case (dmtype)
      DM_WORD:            mis = (addr_lo != 2'b00);
      DM_HALF, DM_HALF_U: mis = addr_lo[0];
      default:            mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// -----------------------------------------------------------------------------
// dm_lane_align
// Purely combinational byte-lane steering for the data-memory access unit.
//   Store path: st_addr_lo, st_dmtype, st_wdata -> st_be, st_wdata_lane
//     (byte enables and store data replicated onto every lane)
//   Load path:  ld_addr_lo, ld_dmtype, ld_rdata -> ld_data
//     (lane selected by the low address bits, then sign/zero extended)
// Reserved dmtype encodings produce zero enables, zero data.
// -----------------------------------------------------------------------------
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  st_addr_lo,
  input  logic [2:0]  st_dmtype,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_lane,
  input  logic [1:0]  ld_addr_lo,
  input  logic [2:0]  ld_dmtype,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [15:0] ld_half;
  logic [7:0]  ld_byte;

  // Store path: replicate data so the bus slave can take whichever lane is enabled
  always_comb begin
    st_be         = 4'b0000;
    st_wdata_lane = 32'h0000_0000;
    case (st_dmtype)
      DM_WORD: begin
        st_be         = 4'b1111;
        st_wdata_lane = st_wdata;
      end
      DM_HALF, DM_HALF_U: begin
        st_be         = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata_lane = {2{st_wdata[15:0]}};
      end
      DM_BYTE, DM_BYTE_U: begin
        st_be         = 4'b0001 << st_addr_lo;
        st_wdata_lane = {4{st_wdata[7:0]}};
      end
      default: begin
        st_be         = 4'b0000;
        st_wdata_lane = 32'h0000_0000;
      end
    endcase
  end

  // Load lane select: half lane by addr[1], byte lane by addr[1:0]
  always_comb begin
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_addr_lo)
      2'b00:   ld_byte = ld_rdata[7:0];
      2'b01:   ld_byte = ld_rdata[15:8];
      2'b10:   ld_byte = ld_rdata[23:16];
      2'b11:   ld_byte = ld_rdata[31:24];
      default: ld_byte = 8'h00;
    endcase
  end

  // Load extension according to the access type
  always_comb begin
    ld_data = 32'h0000_0000;
    case (ld_dmtype)
      DM_WORD:   ld_data = ld_rdata;
      DM_HALF:   ld_data = {{16{ld_half[15]}}, ld_half};
      DM_HALF_U: ld_data = {16'h0000, ld_half};
      DM_BYTE:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      DM_BYTE_U: ld_data = {24'h00_0000, ld_byte};
      default:   ld_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// -----------------------------------------------------------------------------
// dmem_access_unit
// Converts one CPU MEM-stage data access into a single word-aligned bus cycle,
// waits for bus_ready (bounded by TIMEOUT cycles) and returns extended load
// data with an error code. Misaligned and illegal accesses are answered
// directly without touching the bus.
//
// Ports:
//   clk, rst              clock (rising edge), async active-low reset
//   req_valid/we/addr/
//   wdata/dmtype          CPU request
//   req_ready             unit is idle and can accept
//   rsp_valid             one-cycle response strobe
//   rsp_rdata, rsp_err    registered response, held until the next response
//   stall                 CPU must hold its MEM stage
//   bus_req/we/addr/be/
//   wdata                 registered bus cycle outputs, constant while BUSY
//   bus_rdata, bus_ready  bus response
// -----------------------------------------------------------------------------
module dmem_access_unit
  import dm_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_dmtype,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  // Last BUSY cycle index before the access is abandoned
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  dm_state_e         state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [1:0]        addr_lo_q,   addr_lo_d;
  logic [2:0]        dmtype_q,    dmtype_d;
  logic              bus_req_q,   bus_req_d;
  logic              bus_we_q,    bus_we_d;
  logic [31:0]       bus_addr_q,  bus_addr_d;
  logic [3:0]        bus_be_q,    bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_err_q,   rsp_err_d;

  logic [3:0]        st_be;
  logic [31:0]       st_wdata_lane;
  logic [31:0]       ld_data;

  // Store formatting uses the live request; load extraction uses the
  // captured low address bits and type, since bus_addr has them cleared.
  dm_lane_align u_lane_align (
    .st_addr_lo    (req_addr[1:0]),
    .st_dmtype     (req_dmtype),
    .st_wdata      (req_wdata),
    .st_be         (st_be),
    .st_wdata_lane (st_wdata_lane),
    .ld_addr_lo    (addr_lo_q),
    .ld_dmtype     (dmtype_q),
    .ld_rdata      (bus_rdata),
    .ld_data       (ld_data)
  );

  // Next-state and next-output computation for the access FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_lo_d   = addr_lo_q;
    dmtype_d    = dmtype_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_lo_d   = req_addr[1:0];
          dmtype_d    = req_dmtype;
          bus_we_d    = req_we;
          bus_addr_d  = {req_addr[31:2], 2'b00};
          bus_be_d    = st_be;
          bus_wdata_d = st_wdata_lane;
          cnt_d       = {CNT_W{1'b0}};
          if (!dm_is_legal(req_dmtype)) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_ILLEGAL;
            rsp_rdata_d = 32'h0000_0000;
          end else if (dm_is_misaligned(req_dmtype, req_addr[1:0])) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_MISALIGN;
            rsp_rdata_d = 32'h0000_0000;
          end else begin
            state_d   = BUSY;
            bus_req_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end

      BUSY: begin
        // bus_ready takes priority over an expiring timeout at the same edge
        if (bus_ready) begin
          state_d     = RESP;
          bus_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_OK;
          rsp_rdata_d = bus_we_q ? 32'h0000_0000 : ld_data;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d     = RESP;
            bus_req_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_TIMEOUT;
            rsp_rdata_d = 32'h0000_0000;
          end else begin
            state_d = BUSY;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset discards any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      addr_lo_q   <= 2'b00;
      dmtype_q    <= 3'b000;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0000_0000;
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_lo_q   <= addr_lo_d;
      dmtype_q    <= dmtype_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  // The CPU may advance in the cycle the response strobe is visible
  assign stall     = req_valid & ~rsp_valid_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_unit
// Self-checking bench: a table of directed accesses, a randomized run checked
// against a byte-oriented reference model, and hand-written sequences for
// reset state, back-to-back accesses and reset during a bus cycle.
// -----------------------------------------------------------------------------
module tb_dmem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_dmtype;
  logic        req_ready, rsp_valid, stall;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        bus_ready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_access_unit #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_dmtype(req_dmtype), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .stall(stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [2:0]  dt;
    logic        we;
    int          delay;    // BUSY cycles before bus_ready; large = never
    logic [1:0]  e_err;
    logic [31:0] e_rdata;
    logic [3:0]  e_be;
    logic [31:0] e_bwd;
    int          e_busy;   // cycles with bus_req high
    int          e_lat;    // cycles from accept edge to rsp_valid
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, wdata, rd, input logic [2:0] dt,
                              input logic we, input int delay, input logic [1:0] e_err,
                              input logic [31:0] e_rdata, input logic [3:0] e_be,
                              input logic [31:0] e_bwd, input int e_busy, input int e_lat);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.rd = rd; v.dt = dt; v.we = we; v.delay = delay;
    v.e_err = e_err; v.e_rdata = e_rdata; v.e_be = e_be; v.e_bwd = e_bwd;
    v.e_busy = e_busy; v.e_lat = e_lat;
    return v;
  endfunction

  // Reference model: access size in bytes, byte offset in the word,
  // lane replication by modulo, extraction by shift-and-mask.
  function automatic void model(input logic [31:0] addr, wdata, rd, input logic [2:0] dt,
                                input logic we, output logic [1:0] err, output logic [3:0] be,
                                output logic [31:0] bwd, output logic [31:0] rdata);
    int size, off;
    logic [63:0] mask;
    logic [31:0] val;
    size = (dt == 3'd0) ? 4 : (dt == 3'd1 || dt == 3'd2) ? 2 : (dt == 3'd3 || dt == 3'd4) ? 1 : 0;
    off  = int'(addr % 32'd4);
    be = 4'b0000; bwd = 32'h0; rdata = 32'h0;
    if (size == 0) err = 2'd3;
    else if (off % size != 0) err = 2'd1;
    else err = 2'd0;
    if (size != 0) begin
      be = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) bwd[8*i +: 8] = wdata[8*(i % size) +: 8];
    end
    if (err == 2'd0 && !we) begin
      mask = (64'd1 << (8 * size)) - 64'd1;
      val  = 32'((64'(rd) >> (8 * off)) & mask);
      if ((dt == 3'd1 || dt == 3'd3) && val[8*size-1]) val = val | ~mask[31:0];
      rdata = val;
    end
  endfunction

  // Drives one access and acts as the bus; entered and left at a sample point
  task automatic run_access(input vec_t v, input string tag, output int waited);
    int cyc, busy, lat, guard;
    logic stall_bad, held_bad, done;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;
    logic        s_we;
    logic [1:0]  g_err;
    logic [31:0] g_rdata;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    waited = guard;
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    req_dmtype = v.dt; bus_rdata = v.rd; bus_ready = 1'b0;
    #1;
    stall_bad = (stall !== 1'b1);
    held_bad = 1'b0; done = 1'b0;
    busy = 0; lat = 0; g_err = 2'bxx; g_rdata = 32'hx;
    s_addr = 32'h0; s_wdata = 32'h0; s_be = 4'h0; s_we = 1'b0;
    @(posedge clk); #1;
    cyc = 1;
    while (!done && cyc <= 40) begin
      if (bus_req) begin
        busy++;
        if (busy == 1) begin
          s_addr = bus_addr; s_be = bus_be; s_wdata = bus_wdata; s_we = bus_we;
        end else if (bus_addr !== s_addr || bus_be !== s_be || bus_wdata !== s_wdata || bus_we !== s_we) begin
          held_bad = 1'b1;
        end
        bus_ready = (busy - 1 == v.delay);
      end else begin
        bus_ready = 1'b0;
      end
      if (rsp_valid) begin
        lat = cyc; g_err = rsp_err; g_rdata = rsp_rdata;
        if (stall !== 1'b0) stall_bad = 1'b1;
        done = 1'b1;
      end else begin
        if (stall !== 1'b1) stall_bad = 1'b1;
        @(posedge clk); #1;
        cyc++;
      end
    end
    req_valid = 1'b0;
    bus_ready = 1'b0;
    check({tag, "_lat"},   32'(lat),  32'(v.e_lat));
    check({tag, "_err"},   {30'b0, g_err}, {30'b0, v.e_err});
    check({tag, "_rdata"}, g_rdata, v.e_rdata);
    check({tag, "_busy"},  32'(busy), 32'(v.e_busy));
    check({tag, "_stall"}, {31'b0, stall_bad}, 32'd0);
    if (v.e_busy > 0) begin
      check({tag, "_baddr"}, s_addr, {v.addr[31:2], 2'b00});
      check({tag, "_be"},    {28'b0, s_be}, {28'b0, v.e_be});
      check({tag, "_bwd"},   s_wdata, v.e_bwd);
      check({tag, "_bwe"},   {31'b0, s_we}, {31'b0, v.we});
      check({tag, "_held"},  {31'b0, held_bad}, 32'd0);
    end
  endtask

  vec_t tbl[12];

  initial begin
    vec_t v;
    int   waited, bad;
    logic [1:0]  m_err;
    logic [3:0]  m_be;
    logic [31:0] m_bwd, m_rd;

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_dmtype = 3'd0; bus_rdata = 32'h0; bus_ready = 1'b0;

    // Reset state
    #12;
    check("rst_bus_req",   {31'b0, bus_req},   32'd0);
    check("rst_bus_we",    {31'b0, bus_we},    32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_bus_addr",  bus_addr,  32'h0);
    check("rst_bus_be",    {28'b0, bus_be}, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err",   {30'b0, rsp_err}, 32'h0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_stall",     {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    //            addr          wdata         rd            dt    we    dly err   rdata         be       bwd        busy lat
    tbl[0]  = mk(32'h0000_1003, 32'h0000_00A5, 32'h0,        3'd3, 1'b1, 0,  2'd0, 32'h0,        4'b1000, 32'hA5A5A5A5, 1, 2);
    tbl[1]  = mk(32'h0000_2002, 32'h0,         32'h8001FFFF, 3'd1, 1'b0, 0,  2'd0, 32'hFFFF8001, 4'b1100, 32'h0,        1, 2);
    tbl[2]  = mk(32'h0000_2002, 32'h0,         32'h8001FFFF, 3'd2, 1'b0, 0,  2'd0, 32'h00008001, 4'b1100, 32'h0,        1, 2);
    tbl[3]  = mk(32'h0000_3001, 32'h0,         32'h12345678, 3'd0, 1'b0, 0,  2'd1, 32'h0,        4'b0000, 32'h0,        0, 1);
    tbl[4]  = mk(32'h0000_3000, 32'h0,         32'h12345678, 3'd6, 1'b0, 0,  2'd3, 32'h0,        4'b0000, 32'h0,        0, 1);
    tbl[5]  = mk(32'h0000_4000, 32'h0,         32'h12345678, 3'd0, 1'b0, 99, 2'd2, 32'h0,        4'b1111, 32'h0,        4, 5);
    tbl[6]  = mk(32'h0000_4004, 32'h0,         32'hCAFEBABE, 3'd0, 1'b0, 3,  2'd0, 32'hCAFEBABE, 4'b1111, 32'h0,        4, 5);
    tbl[7]  = mk(32'h0000_5002, 32'h0000BEEF,  32'h0,        3'd1, 1'b1, 0,  2'd0, 32'h0,        4'b1100, 32'hBEEFBEEF, 1, 2);
    tbl[8]  = mk(32'h0000_6001, 32'h0,         32'h11228344, 3'd4, 1'b0, 0,  2'd0, 32'h00000083, 4'b0010, 32'h0,        1, 2);
    tbl[9]  = mk(32'h0000_6001, 32'h0,         32'h11228344, 3'd3, 1'b0, 0,  2'd0, 32'hFFFFFF83, 4'b0010, 32'h0,        1, 2);
    tbl[10] = mk(32'h0000_7000, 32'hDEADBEEF,  32'h0,        3'd0, 1'b1, 1,  2'd0, 32'h0,        4'b1111, 32'hDEADBEEF, 2, 3);
    tbl[11] = mk(32'h0000_8003, 32'h00001234,  32'h0,        3'd2, 1'b1, 0,  2'd1, 32'h0,        4'b0000, 32'h0,        0, 1);

    for (int i = 0; i < 12; i++) begin
      run_access(tbl[i], $sformatf("tbl%0d", i), waited);
    end

    // Response is held after the strobe
    @(posedge clk); #1;
    check("hold_valid", {31'b0, rsp_valid}, 32'd0);
    check("hold_err",   {30'b0, rsp_err}, 32'd1);

    // Back-to-back word loads with bus_ready immediately
    run_access(mk(32'h10, 32'h0, 32'h11111111, 3'd0, 1'b0, 0, 2'd0, 32'h11111111, 4'b1111, 32'h0, 1, 2), "b2b_a", waited);
    check("b2b_resp_not_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check("b2b_strobe_once", {31'b0, rsp_valid}, 32'd0);
    check("b2b_idle_ready",  {31'b0, req_ready}, 32'd1);
    check("b2b_rdata_held",  rsp_rdata, 32'h11111111);
    run_access(mk(32'h14, 32'h0, 32'h22222222, 3'd0, 1'b0, 0, 2'd0, 32'h22222222, 4'b1111, 32'h0, 1, 2), "b2b_b", waited);
    check("b2b_no_wait", 32'(waited), 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of a bus cycle
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_dmtype = 3'd0; bus_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_busy", {31'b0, bus_req}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_bus_req", {31'b0, bus_req}, 32'd0);
    check("mid_ready",   {31'b0, req_ready}, 32'd1);
    check("mid_rsp",     {31'b0, rsp_valid}, 32'd0);
    check("mid_addr",    bus_addr, 32'h0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || bus_req !== 1'b0) bad++;
    end
    check("mid_quiet", 32'(bad), 32'd0);
    run_access(mk(32'h44, 32'h0, 32'h0BADF00D, 3'd0, 1'b0, 0, 2'd0, 32'h0BADF00D, 4'b1111, 32'h0, 1, 2), "post_rst", waited);

    // Randomized accesses against the reference model
    for (int i = 0; i < 80; i++) begin
      v.addr  = $urandom;
      v.wdata = $urandom;
      m_rd    = $urandom;
      v.rd    = m_rd;
      v.dt    = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      v.we    = 1'($urandom_range(0, 1));
      v.delay = $urandom_range(0, 5);
      model(v.addr, v.wdata, v.rd, v.dt, v.we, m_err, m_be, m_bwd, v.e_rdata);
      v.e_err = m_err; v.e_be = m_be; v.e_bwd = m_bwd;
      if (m_err == 2'd0) begin
        v.e_busy = (v.delay + 1 > TO) ? TO : v.delay + 1;
        if (v.delay + 1 > TO) begin
          v.e_err = 2'd2;
          v.e_rdata = 32'h0;
        end
      end else begin
        v.e_busy = 0;
      end
      v.e_lat = (v.e_busy == 0) ? 1 : v.e_busy + 1;
      run_access(v, $sformatf("rnd%0d", i), waited);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Sits directly downstream of the pipelined CPU's MEM stage and consumes its data-memory request: address, store data, write flag and DMType.
- Turns each request into one word-aligned bus cycle with byte enables and lane-replicated store data.
- Waits on a ready handshake with a timeout, then returns lane-extracted, sign- or zero-extended load data plus an error code.
- Drives a stall so the CPU holds its MEM stage until the response arrives.

Parameters:
- TIMEOUT, 255: maximum number of BUSY cycles without bus_ready before the access is aborted (range 1..65535).
- CNT_W, 16: width of the timeout counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  CPU presents a memory access.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- req_dmtype  in  3  access type: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned.
- req_ready  out  1  unit can accept a request this cycle.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  extended load data; 0 for stores and on error.
- rsp_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal dmtype.
- stall  out  1  CPU must hold its MEM stage.
- bus_req  out  1  bus cycle active.
- bus_we  out  1  bus write.
- bus_addr  out  32  word address; req_addr with bits [1:0] forced to 00.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  bus read word.
- bus_ready  in  1  bus completes the cycle at this edge.

Behaviour:
- States: IDLE, BUSY, RESP.
  - req_ready = (state==IDLE).
  - stall = req_valid & ~rsp_valid.
- Reset (rst=0, asynchronous):
  - state goes to IDLE; timeout counter goes to 0.
  - bus_req, bus_we, rsp_valid go to 0.
  - bus_addr, bus_be, bus_wdata, rsp_rdata, rsp_err go to 0.
  - Applies mid-access: bus_req drops immediately, no response is issued, and the captured request is discarded.
- IDLE:
  - Accept happens on the edge where req_valid=1.
  - Address, we, dmtype and lane-formatted data are registered at that edge.
  - Legal, aligned request: go to BUSY with bus_req=1 from the next cycle.
  - Misaligned request: go straight to RESP with no bus cycle. Misaligned means half/half-unsigned with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal dmtype (101..111): same as misaligned, with rsp_err=11.
- BUSY:
  - bus_* outputs are held constant.
  - The counter increments every cycle that bus_ready=0.
  - bus_ready=1 at an edge: capture bus_rdata, go to RESP with err 00.
  - Counter reaches TIMEOUT-1 with bus_ready=0: go to RESP with err 10 and rdata 0.
  - bus_ready and timeout at the same edge: bus_ready wins.
  - bus_req deasserts on leaving BUSY.
- RESP:
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - A new request can be accepted on the edge after RESP, never in RESP.
- Minimum latency: accept edge, then bus_ready on the next edge, then rsp_valid in the following cycle. That is 2 cycles from accept to rsp_valid.
- Store formatting:
  - Byte: bus_wdata = {4{wdata[7:0]}}, be = 0001 << addr[1:0].
  - Half: bus_wdata = {2{wdata[15:0]}}, be = addr[1] ? 1100 : 0011.
  - Word: be = 1111.
  - Loads: be is the same pattern as for stores; bus_we=0.
- Load extraction:
  - Select the byte/half lane from the registered addr[1:0].
  - Types 001 and 011 sign-extend; types 010 and 100 zero-extend; word passes through unchanged.
  - rsp_rdata=0 for stores and for any error.
- rsp_rdata and rsp_err are registered and hold their value until the next RESP.

Decomposition:
- Shared package dm_pkg holds:
  - DM_WORD, DM_HALF, DM_HALF_U, DM_BYTE, DM_BYTE_U encodings.
  - ERR_OK, ERR_MISALIGN, ERR_TIMEOUT, ERR_ILLEGAL.
  - The state encoding IDLE/BUSY/RESP.
- One combinational sub-module, dm_lane_align: store path (addr[1:0], dmtype, wdata → be, bus_wdata) and load path (addr[1:0], dmtype, bus_rdata → extended data).
- The FSM and counter stay in the top module.

Test Plan:
- Store byte: addr=0x1003, wdata=0x000000A5, dmtype=011, bus_ready next cycle → bus_addr=0x1000, be=1000, bus_wdata=0xA5A5A5A5; rsp_valid 2 cycles after accept; err=00, rdata=0.
- Load half signed: addr=0x2002, bus_rdata=0x8001FFFF, dmtype=001 → rsp_rdata=0xFFFF8001. Same with dmtype=010 → 0x00008001.
- Misaligned word load at 0x3001 → no bus_req pulse; rsp_valid the cycle after accept; err=01, rdata=0. Illegal dmtype 110 → err=11.
- Timeout: TIMEOUT=4, bus_ready held 0 → bus_req high exactly 4 cycles, then rsp err=10. With bus_ready rising in the 4th BUSY cycle → err=00 and data captured.
- Reset mid-access: drop rst while in BUSY → bus_req=0 and state IDLE immediately, no rsp_valid; after release req_ready=1 and the next access completes normally.
- Stall/back-to-back: two word loads 0x10 and 0x14 with bus_ready always 1 → stall high until each rsp_valid; second accept on the cycle after the first RESP.
